// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the hex keypad entry block:
//   - KP_DIM        : number of keypad rows and columns (4)
//   - fsm_state_t   : debounce FSM state type with its state constants
//   - KEY_MAP       : 16-entry table, index row*4+col -> 4-bit key code
//   - key_lookup()  : table accessor used by the scan reduction
package keypad_pkg;

    localparam int KP_DIM = 4;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE       = 2'd0;
    localparam fsm_state_t ST_PRESS_DB   = 2'd1;
    localparam fsm_state_t ST_HELD       = 2'd2;
    localparam fsm_state_t ST_RELEASE_DB = 2'd3;

    // Element [row*4+col]; listed from index 15 (row 3, col 3) down to 0.
    // Row 3 carries '*' as E and '#' as F.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan
// Drives the keypad rows one at a time, samples the synchronized columns at
// the end of each row dwell and reduces one full scan to a single result.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   col_n[3:0]   : raw column sense (active low, asynchronous)
//   row_n[3:0]   : row drive (active low, one-cold)
//   scan_done    : one-cycle pulse, one cycle after the row-3 sample
//   scan_single  : with scan_done, exactly one key was seen in the scan
//   scan_code    : with scan_done and scan_single, code of that key
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       scan_done,
    output logic       scan_single,
    output logic [3:0] scan_code
);

    localparam int DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [3:0]         col_meta_reg;
    logic [3:0]         col_sync_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic [1:0]         row_idx_reg;
    logic [3:0][3:0]    samples_reg;     // [row][col], 1 = pressed
    logic [3:0]         sample_en;
    logic               last_dwell;
    logic               reduce_pending_reg;
    logic               scan_done_reg;
    logic               scan_single_reg;
    logic [3:0]         scan_code_reg;

    logic [15:0]        sample_bits;
    logic [4:0]         press_count;
    logic [3:0]         hit_idx;

    assign last_dwell = (dwell_reg == DWELL_LAST);
    assign row_n      = ~(4'b0001 << row_idx_reg);

    // Two-flop synchronizer on the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
        end else begin
            col_meta_reg <= col_n;
            col_sync_reg <= col_meta_reg;
        end
    end

    // Row dwell counter and row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg   <= '0;
            row_idx_reg <= 2'd0;
        end else if (last_dwell) begin
            dwell_reg   <= '0;
            row_idx_reg <= row_idx_reg + 2'd1;
        end else begin
            dwell_reg   <= dwell_reg + DWELL_W'(1);
        end
    end

    // Per-row sample strobe: last dwell cycle of the row currently driven.
    // The sample taken here sees columns that settled at least two cycles
    // after the row drive changed, hence the minimum dwell of 4.
    genvar gi;
    generate
        for (gi = 0; gi < KP_DIM; gi++) begin : g_row_en
            assign sample_en[gi] = last_dwell && (row_idx_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            samples_reg <= '0;
        end else begin
            for (int r = 0; r < KP_DIM; r++) begin
                if (sample_en[r]) begin
                    samples_reg[r] <= ~col_sync_reg;
                end
            end
        end
    end

    // The row-3 sample edge arms the reduction; the result registers one
    // cycle later, when all four rows are in samples_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            reduce_pending_reg <= 1'b0;
        end else begin
            reduce_pending_reg <= sample_en[3];
        end
    end

    assign sample_bits = samples_reg;

    // Count pressed keys and remember the position of one of them; the
    // position is only meaningful when the count is exactly one.
    always_comb begin
        press_count = 5'd0;
        hit_idx     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sample_bits[i]) begin
                press_count = press_count + 5'd1;
                hit_idx     = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_done_reg   <= 1'b0;
            scan_single_reg <= 1'b0;
            scan_code_reg   <= 4'd0;
        end else begin
            scan_done_reg <= reduce_pending_reg;
            if (reduce_pending_reg) begin
                // Zero or multiple presses both reduce to NONE; multiple
                // presses can be ghosts of the matrix, so they are not trusted.
                scan_single_reg <= (press_count == 5'd1);
                scan_code_reg   <= key_lookup(hit_idx);
            end
        end
    end

    assign scan_done   = scan_done_reg;
    assign scan_single = scan_single_reg;
    assign scan_code   = scan_code_reg;

endmodule

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
// Debounces single key presses from the keypad scanner and shifts each
// accepted hex digit into a 16-bit value from the right.
// Parameters:
//   SCAN_DIV       : clock cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS : matching full scans needed for press/release (1..255)
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   row_n[3:0]   : keypad row drive, active low
//   col_n[3:0]   : keypad column sense, active low, asynchronous
//   clr          : synchronous clear of value (wins over a same-cycle accept)
//   value[15:0]  : assembled hex value, [3:0] is the newest digit
//   key_code[3:0]: most recently accepted key
//   key_valid    : one-cycle pulse on accept
//   key_held     : high while the accepted key remains pressed
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    input  logic        clr,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_SCANS);

    logic       scan_done;
    logic       scan_single;
    logic [3:0] scan_code;

    fsm_state_t  state_reg, state_next;
    logic [7:0]  db_cnt_reg, db_cnt_next;
    logic [7:0]  db_inc;
    logic [3:0]  cand_reg, cand_next;
    logic        accept;
    logic [3:0]  accept_code;
    logic [15:0] value_reg;
    logic [3:0]  key_code_reg;
    logic        key_valid_reg;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .col_n       (col_n),
        .row_n       (row_n),
        .scan_done   (scan_done),
        .scan_single (scan_single),
        .scan_code   (scan_code)
    );

    assign db_inc = db_cnt_reg + 8'd1;

    // Debounce FSM; only advances on a completed scan.
    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt_reg;
        cand_next   = cand_reg;
        accept      = 1'b0;
        accept_code = cand_reg;
        if (scan_done) begin
            case (state_reg)
                ST_IDLE: begin
                    if (scan_single) begin
                        cand_next   = scan_code;
                        accept_code = scan_code;
                        if (DB_TARGET == 8'd1) begin
                            accept      = 1'b1;
                            state_next  = ST_HELD;
                            db_cnt_next = 8'd0;
                        end else begin
                            state_next  = ST_PRESS_DB;
                            db_cnt_next = 8'd1;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (!scan_single) begin
                        state_next  = ST_IDLE;
                        db_cnt_next = 8'd0;
                    end else if (scan_code != cand_reg) begin
                        cand_next   = scan_code;
                        db_cnt_next = 8'd1;
                    end else if (db_inc == DB_TARGET) begin
                        accept      = 1'b1;
                        state_next  = ST_HELD;
                        db_cnt_next = 8'd0;
                    end else begin
                        db_cnt_next = db_inc;
                    end
                end
                ST_HELD: begin
                    // A different single key while held is ignored (no rollover).
                    if (!scan_single) begin
                        if (DB_TARGET == 8'd1) begin
                            state_next  = ST_IDLE;
                            db_cnt_next = 8'd0;
                        end else begin
                            state_next  = ST_RELEASE_DB;
                            db_cnt_next = 8'd1;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (scan_single) begin
                        state_next  = ST_HELD;
                        db_cnt_next = 8'd0;
                    end else if (db_inc == DB_TARGET) begin
                        state_next  = ST_IDLE;
                        db_cnt_next = 8'd0;
                    end else begin
                        db_cnt_next = db_inc;
                    end
                end
                default: begin
                    state_next  = ST_IDLE;
                    db_cnt_next = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            db_cnt_reg <= 8'd0;
            cand_reg   <= 4'd0;
        end else begin
            state_reg  <= state_next;
            db_cnt_reg <= db_cnt_next;
            cand_reg   <= cand_next;
        end
    end

    // Outputs of an accept; clr only touches value and takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg     <= 16'd0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
        end else begin
            key_valid_reg <= accept;
            if (accept) begin
                key_code_reg <= accept_code;
            end
            if (clr) begin
                value_reg <= 16'd0;
            end else if (accept) begin
                value_reg <= {value_reg[11:0], accept_code};
            end
        end
    end

    assign value     = value_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = (state_reg == ST_HELD) || (state_reg == ST_RELEASE_DB);

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Testbench for hex_keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Key stimulus changes only at scan boundaries; a run-length reference model
// predicts accepts, which a separate monitor matches against key_valid.
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = 16'h0000;   // bit r*4+c = key (r,c) pressed

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    typedef struct {
        int code;
        int value;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    int m_value    = 0;
    int m_run_code = -1;
    int m_run_len  = 0;
    int m_none_len = 0;
    bit m_locked   = 0;
    bit clr_pending = 0;
    bit clr_fire    = 0;
    bit clr_now     = 0;
    int fire_code   = 0;
    bit kv_prev     = 0;

    hex_keypad_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .clr       (clr),
        .value     (value),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key shorts its column to its driven row.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One full scan worth of keypad state, judged by the keypad's rules.
    task automatic model_scan(input logic [15:0] mask, input int start);
        int code;
        code = -1;
        if ($countones(mask) == 1) begin
            for (int i = 0; i < 16; i++) if (mask[i]) code = key_map[i];
        end
        if (!m_locked) begin
            if (code >= 0) begin
                if (m_run_len > 0 && code == m_run_code) m_run_len++;
                else begin
                    m_run_code = code;
                    m_run_len  = 1;
                end
                if (m_run_len == DS) begin
                    m_locked   = 1;
                    m_none_len = 0;
                    m_run_len  = 0;
                    if (clr_pending) begin
                        m_value     = 0;
                        clr_fire    = 1;
                        fire_code   = code;
                        clr_pending = 0;
                    end else begin
                        m_value = ((m_value << 4) | code) & 16'hFFFF;
                    end
                    // result registers 1 cycle after the row-3 sample, FSM 1 after that
                    exp_q.push_back('{code, m_value, start + SCAN_LEN + 2});
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (code >= 0) m_none_len = 0;
            else begin
                m_none_len++;
                if (m_none_len == DS) m_locked = 0;
            end
        end
    endtask

    // Called half a cycle after a scan starts; returns at the next scan start.
    task automatic step(input logic [15:0] mask);
        int start;
        bit seen;
        bit done;
        keys  = mask;
        start = cyc;
        @(negedge clk);
        if (clr_fire || clr_now) clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        if (clr_fire) begin
            chk("clr_hit_valid", int'(key_valid), 1);
            chk("clr_hit_code", int'(key_code), fire_code);
            chk("clr_hit_value", int'(value), 0);
            clr_fire = 0;
        end
        if (clr_now) begin
            m_value = 0;
            clr_now = 0;
        end
        @(negedge clk);
        chk("key_held", int'(key_held), int'(m_locked));
        chk("value", int'(value), m_value);
        model_scan(mask, start);
        seen = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (row_n != 4'b1110) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) chk("scan_boundary_timeout", 0, 1);
    endtask

    task automatic press(input logic [15:0] mask, input int n, input int rel);
        repeat (n) step(mask);
        repeat (rel) step(16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_row_n", int'(row_n), 4'b1110);
        chk("rst_value", int'(value), 0);
        chk("rst_key_code", int'(key_code), 0);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_held", int'(key_held), 0);
        m_value    = 0;
        m_run_len  = 0;
        m_none_len = 0;
        m_locked   = 0;
        rst = 1'b0;
    endtask

    // Monitor: every key_valid pulse must match the next predicted accept.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            chk("kv_spacing", int'(kv_prev), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_key_valid", int'(key_code), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("accept: code=%0h value=%04h cycle=%0d", key_code, value, cyc);
                chk("accept_code", int'(key_code), e.code);
                chk("accept_value", int'(value), e.value);
                chk("accept_cycle", cyc, e.cyc);
            end
        end
        kv_prev <= key_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int b1, b2;

        do_reset();

        // single press (1,2) -> 6
        press(16'h0040, 10, 4);
        chk("single_value", int'(value), 16'h0006);

        // digit sequence 1,2,3,A,4
        clr_now = 1;
        step(16'h0000);
        press(16'h0001, 5, 4);
        press(16'h0002, 5, 4);
        press(16'h0004, 5, 4);
        press(16'h0008, 5, 4);
        press(16'h0010, 5, 4);
        chk("seq_value", int'(value), 16'h23A4);

        // bounce and ghosting
        press(16'h0001, 2, 4);
        press(16'h0021, 10, 4);

        // held 0 plus 7, then 7 alone after full release
        repeat (4) step(16'h2000);
        repeat (4) step(16'h2100);
        repeat (4) step(16'h0000);
        press(16'h0100, 4, 4);
        // direct swap from 8 to 9 while held: no accept of 9
        repeat (4) step(16'h0200);
        repeat (4) step(16'h0400);
        repeat (4) step(16'h0000);

        // clear collides with accept of F
        clr_now = 1;
        step(16'h0000);
        press(16'h0001, 4, 4);
        press(16'h0002, 4, 4);
        press(16'h0004, 4, 4);
        press(16'h0010, 4, 4);
        chk("pre_clr_value", int'(value), 16'h1234);
        repeat (2) step(16'h4000);
        clr_pending = 1;
        repeat (2) step(16'h4000);
        repeat (4) step(16'h0000);

        // reset during press debounce at db_cnt = 2, key kept pressed
        repeat (2) step(16'h0020);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (4) step(16'h0020);
        repeat (4) step(16'h0000);

        // randomized segments
        for (int s = 0; s < 25; s++) begin
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 2))
                0: m = 16'h0000;
                1: m = 16'h0001 << b1;
                default: m = (16'h0001 << b1) | (16'h0001 << b2);
            endcase
            repeat ($urandom_range(1, 6)) step(m);
        end
        repeat (4) step(16'h0000);

        repeat (40) @(negedge clk);
        chk("pending_accepts", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
